uart_tx_fifo: RTL and testbench

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the host/bus side at full clock rate, stores up to DEPTH entries, and feeds the transmitter one byte at a time. It uses a start-pulse / done-pulse handshake and holds each byte stable for the whole frame. This decouples bursty producers from the slow serial line.

---
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter through a start/done pulse handshake.
// Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module uart_tx_fifo #(
    parameter int D_W   = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [D_W-1:0]         wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   tx_start,
    output logic [D_W-1:0]         tx_byte,
    input  logic                   tx_done,
    output logic                   tx_busy,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [D_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     state_q, state_d;
    logic [D_W-1:0] tx_byte_q, tx_byte_d;
    logic           wr_acc;
    logic           wr_drop;
    logic           pop;

    // Full is judged on the pre-pop count, so a write racing a pop on a full FIFO is dropped.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign wr_acc  = wr_en && !full;
    assign wr_drop = wr_en && full;
    assign pop     = (state_q == IDLE) && !empty;

    assign tx_start = (state_q == SEND);
    assign tx_busy  = (state_q != IDLE);
    assign tx_byte  = tx_byte_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CW'(wr_acc) - CW'(pop);
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    tx_byte_d = mem_q[rd_ptr_q];
                    state_d   = SEND;
                end
            end
            SEND:    state_d = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage array carries no reset; occupancy is governed entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            tx_byte_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ wr_drop;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus a randomized phase, all outputs compared
// every cycle against a queue-based reference model of the FIFO and handoff rules.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       full, empty, tx_start, tx_busy, ovf;
    logic [4:0] level;
    logic [7:0] tx_byte;

    uart_tx_fifo #(.D_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level),
        .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
        .tx_busy(tx_busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: bytes waiting in the FIFO, plus the handed-off frame status.
    logic [7:0] m_q[$];
    logic       m_idle = 1'b1;
    logic       m_start = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic pop, drop, was_start;
        if (rst) begin
            m_q.delete();
            m_idle  = 1'b1;
            m_start = 1'b0;
            m_byte  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            pop       = m_idle && (m_q.size() != 0);
            drop      = wr_en && (m_q.size() == DEPTH);
            was_start = m_start;
            m_start   = pop;
            if (pop) begin
                m_byte = m_q.pop_front();
                m_idle = 1'b0;
            end else if (!m_idle && !was_start && tx_done) begin
                m_idle = 1'b1;
            end
            if (wr_en && !drop) m_q.push_back(wr_data);
            if (OVF_ON) begin
                if (drop) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level",    32'(level),    32'(m_q.size()));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_busy",  32'(tx_busy),  32'(!m_idle));
        chk("tx_byte",  32'(tx_byte),  32'(m_byte));
        chk("ovf",      32'(ovf),      32'(m_ovf));
    endtask

    logic       auto_resp = 1'b0;
    int         resp_delay = 50;
    int         cd = 0;
    int         n_start = 0;
    logic [7:0] starts[$];

    // Advance one cycle: check, drop one-cycle pulses, record handoffs, run the responder.
    task automatic tick();
        @(negedge clk);
        check_all();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        tx_done = 1'b0;
        if (tx_start) begin
            n_start++;
            starts.push_back(tx_byte);
        end
        if (auto_resp) begin
            if (tx_start) cd = resp_delay;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done = 1'b1;
            end
        end
    endtask

    initial begin
        int guard;
        int ns;
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // Single byte handoff
        wr_en = 1'b1; wr_data = 8'hA5; tick();
        chk("t1_empty_c1", 32'(empty), 32'd0);
        chk("t1_nostart_c1", 32'(tx_start), 32'd0);
        tick();
        chk("t1_start_c2", 32'(tx_start), 32'd1);
        chk("t1_byte_c2", 32'(tx_byte), 32'hA5);
        chk("t1_busy_c2", 32'(tx_busy), 32'd1);
        repeat (19) tick();
        tx_done = 1'b1; tick();
        chk("t1_busy_after_done", 32'(tx_busy), 32'd0);
        chk("t1_empty_after_done", 32'(empty), 32'd1);
        tx_done = 1'b1; tick();
        chk("t1_idle_done_busy", 32'(tx_busy), 32'd0);
        repeat (4) tick();
        chk("t1_start_count", 32'(n_start), 32'd1);

        // Burst of 16 bytes with a slow transmitter
        starts.delete(); n_start = 0; auto_resp = 1'b1; resp_delay = 50;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); tick();
        end
        guard = 0;
        while ((n_start < 16 || tx_busy) && guard < 2000) begin
            tick();
            guard++;
        end
        chk("t2_timeout", 32'(guard < 2000), 32'd1);
        chk("t2_count", 32'(n_start), 32'd16);
        for (int i = 0; i < 16; i++)
            chk("t2_order", (i < starts.size()) ? 32'(starts[i]) : 32'hFFFF_FFFF, 32'(i));
        auto_resp = 1'b0; cd = 0;

        // Fill while the transmitter is held, then overflow
        wr_en = 1'b1; wr_data = 8'h80; tick(); tick();
        chk("t3_handoff", 32'(tx_start), 32'd1);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h81 + i); tick();
        end
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level16", 32'(level), 32'd16);
        wr_en = 1'b1; wr_data = 8'hFF; tick();
        chk("t3_level_after_drop", 32'(level), 32'd16);
        chk("t3_ovf", 32'(ovf), 32'(OVF_ON));
        ovf_clr = 1'b1; tick();
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        // Write on a full FIFO in the pop cycle is dropped
        tx_done = 1'b1; tick();
        wr_en = 1'b1; wr_data = 8'hEE; tick();
        chk("t4_level15", 32'(level), 32'd15);
        chk("t4_next_byte", 32'(tx_byte), 32'h81);

        // tx_done during SEND is ignored
        ns = n_start;
        tx_done = 1'b1; ovf_clr = 1'b1; tick();
        chk("t5_busy", 32'(tx_busy), 32'd1);
        chk("t5_nostart", 32'(tx_start), 32'd0);
        repeat (3) tick();
        chk("t5_start_count", 32'(n_start), 32'(ns));
        chk("t5_ovf_cleared", 32'(ovf), 32'd0);

        // Reset during WAIT with 5 bytes queued
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i); tick();
        end
        chk("t6_level5", 32'(level), 32'd5);
        chk("t6_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1; tick();
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_full", 32'(full), 32'd0);
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_busy", 32'(tx_busy), 32'd0);
        chk("t6_rst_byte", 32'(tx_byte), 32'd0);
        chk("t6_rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        wr_en = 1'b1; wr_data = 8'h3C; tick(); tick();
        chk("t6_first_start", 32'(tx_start), 32'd1);
        chk("t6_first_byte", 32'(tx_byte), 32'h3C);
        tx_done = 1'b1; tick();

        // Randomized traffic with a variable-latency transmitter
        auto_resp = 1'b1; cd = 0;
        for (int k = 0; k < 600; k++) begin
            if (cd == 0 && !tx_busy) resp_delay = $urandom_range(1, 6);
            wr_en   = ($urandom_range(0, 99) < 60);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 19) == 0);
            if (!tx_busy && $urandom_range(0, 9) == 0) tx_done = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
